// File: rtl/seq_detect_ctrl.sv
// Programmable serial bit-pattern detector with a config handshake and run sequencing.
// A run ends on a match target, on expiry of a cycle window, or on abort.
module seq_detect_ctrl #(
    parameter int PAT_W = 4,
    parameter int LEN_W = 3,
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic [WIN_W-1:0] cfg_window,
    output logic             cfg_err,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic             in,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             busy,
    output logic             done,
    output logic             timeout
);

    typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

    state_t           state_q;
    logic [PAT_W-1:0] pat_q, hist_q, hist_d, mask;
    logic [LEN_W-1:0] len_q, bitcnt_q, bitcnt_d, bitcnt_post;
    logic             ovl_q;
    logic [CNT_W-1:0] tgt_q, count_q, count_d;
    logic [WIN_W-1:0] win_q, wincnt_q, wincnt_d;
    logic             match_q, cfg_err_q, busy_q, done_q, timeout_q;
    logic             hit, target_end, window_end, cfg_fire, cfg_legal;

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        hist_d   = hist_q;
        bitcnt_d = bitcnt_q;
        if (in_valid) begin
            hist_d = {hist_q[PAT_W-2:0], in};
            if (bitcnt_q < len_q) bitcnt_d = bitcnt_q + 1'b1;
        end
        // Only the newest len_q history bits take part in the compare.
        mask        = ~({PAT_W{1'b1}} << len_q);
        hit         = in_valid && (bitcnt_d >= len_q) && ((hist_d & mask) == (pat_q & mask));
        bitcnt_post = (hit && !ovl_q) ? '0 : bitcnt_d;
        count_d     = (hit && count_q != '1) ? count_q + 1'b1 : count_q;
        wincnt_d    = wincnt_q + 1'b1;
        target_end  = hit && (tgt_q != '0) && (count_d == tgt_q);
        window_end  = (win_q != '0) && (wincnt_d == win_q);
        cfg_fire    = cfg_valid && (state_q != RUN);
        cfg_legal   = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
    end

    // NOTE: sequential state is assigned only with non-blocking <= so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            ovl_q     <= 1'b0;
            tgt_q     <= '0;
            win_q     <= '0;
            hist_q    <= '0;
            bitcnt_q  <= '0;
            wincnt_q  <= '0;
            count_q   <= '0;
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;
            if (state_q == RUN) begin
                wincnt_q <= wincnt_d;
                hist_q   <= hist_d;
                bitcnt_q <= bitcnt_post;
                count_q  <= count_d;
                match_q  <= hit;
                // Abort beats both run-end causes; a target hit beats window expiry.
                if (abort) begin
                    state_q <= ARMED;
                    busy_q  <= 1'b0;
                end else if (target_end) begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else if (window_end) begin
                    state_q   <= DONE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    timeout_q <= 1'b1;
                end
            end else if (cfg_fire) begin
                if (!cfg_legal) begin
                    cfg_err_q <= 1'b1;
                end else begin
                    state_q   <= ARMED;
                    pat_q     <= cfg_pattern;
                    len_q     <= cfg_len;
                    ovl_q     <= cfg_overlap;
                    tgt_q     <= cfg_target;
                    win_q     <= cfg_window;
                    done_q    <= 1'b0;
                    timeout_q <= 1'b0;
                end
            end else if (start && state_q != IDLE) begin
                state_q   <= RUN;
                busy_q    <= 1'b1;
                done_q    <= 1'b0;
                timeout_q <= 1'b0;
                hist_q    <= '0;
                bitcnt_q  <= '0;
                wincnt_q  <= '0;
                count_q   <= '0;
            end
        end
    end

    assign cfg_ready   = (state_q != RUN);
    assign cfg_err     = cfg_err_q;
    assign match       = match_q;
    assign match_count = count_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: one task per scenario, inline comparisons
// against hand-derived expectations, single summary line at the end.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_valid, cfg_ready, cfg_overlap, cfg_err;
    logic [3:0] cfg_pattern;
    logic [2:0] cfg_len;
    logic [7:0] cfg_target, match_count;
    logic [15:0] cfg_window;
    logic       start, abort, in_valid, in_bit;
    logic       match, busy, done, timeout;

    int n_checks = 0;
    int n_fail   = 0;

    seq_detect_ctrl #(.PAT_W(4), .LEN_W(3), .CNT_W(8), .WIN_W(16)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
        .cfg_window(cfg_window), .cfg_err(cfg_err),
        .start(start), .abort(abort), .in_valid(in_valid), .in(in_bit),
        .match(match), .match_count(match_count), .busy(busy), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_cfg(input logic [2:0] len, input logic [3:0] pat, input logic ovl,
                             input logic [7:0] tgt, input logic [15:0] win);
        cfg_valid = 1'b1; cfg_len = len; cfg_pattern = pat; cfg_overlap = ovl;
        cfg_target = tgt; cfg_window = win;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic send(input logic b);
        in_valid = 1'b1; in_bit = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_checks++;
        if ({cfg_ready, busy, done, timeout, match, cfg_err} !== 6'b100000 || match_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy/busy/done/to/match/err=%b cnt=%0d want 100000 cnt=0",
                     {cfg_ready, busy, done, timeout, match, cfg_err}, match_count);
        end
        tick(); tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if ({cfg_ready, busy, done} !== 3'b100) begin
            n_fail++;
            $display("FAIL post_reset: got rdy/busy/done=%b want 100", {cfg_ready, busy, done});
        end
    endtask

    task automatic test_overlap();
        logic [6:0] bits = 7'b1011011;
        logic [6:0] seen;
        apply_cfg(3'd4, 4'b1011, 1'b1, 8'd0, 16'd0);
        do_start();
        n_checks++;
        if (busy !== 1'b1 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL run_busy: got busy=%b rdy=%b want 1 0", busy, cfg_ready);
        end
        for (int i = 6; i >= 0; i--) begin send(bits[i]); seen[i] = match; end
        n_checks++;
        if (seen !== 7'b0001001) begin
            n_fail++;
            $display("FAIL overlap_match_seq: got %b want 0001001", seen);
        end
        n_checks++;
        if (match_count !== 8'd2) begin
            n_fail++;
            $display("FAIL overlap_count: got %0d want 2", match_count);
        end
        do_abort();
    endtask

    task automatic test_no_overlap();
        logic [6:0] bits = 7'b1011011;
        logic [6:0] seen;
        apply_cfg(3'd4, 4'b1011, 1'b0, 8'd0, 16'd0);
        do_start();
        for (int i = 6; i >= 0; i--) begin send(bits[i]); seen[i] = match; end
        n_checks++;
        if (seen !== 7'b0001000 || match_count !== 8'd1) begin
            n_fail++;
            $display("FAIL no_overlap: got seq=%b cnt=%0d want 0001000 cnt=1", seen, match_count);
        end
        do_abort();
    endtask

    task automatic test_target();
        logic [7:0] bits = 8'b10110110;
        logic [6:0] seen;
        apply_cfg(3'd4, 4'b1011, 1'b1, 8'd2, 16'd0);
        do_start();
        for (int i = 7; i >= 1; i--) begin send(bits[i]); seen[i-1] = match; end
        n_checks++;
        if (seen !== 7'b0001001) begin
            n_fail++;
            $display("FAIL target_match_seq: got %b want 0001001", seen);
        end
        n_checks++;
        if ({done, timeout, busy, cfg_ready} !== 4'b1001 || match_count !== 8'd2) begin
            n_fail++;
            $display("FAIL target_done: got done/to/busy/rdy=%b cnt=%0d want 1001 cnt=2",
                     {done, timeout, busy, cfg_ready}, match_count);
        end
        send(bits[0]); send(1'b1); send(1'b0); send(1'b1); send(1'b1);
        n_checks++;
        if (match_count !== 8'd2 || done !== 1'b1 || match !== 1'b0) begin
            n_fail++;
            $display("FAIL target_ignore_after: got cnt=%0d done=%b match=%b want 2 1 0",
                     match_count, done, match);
        end
        do_start();
        n_checks++;
        if ({busy, done} !== 2'b10 || match_count !== 8'd0) begin
            n_fail++;
            $display("FAIL restart_from_done: got busy/done=%b cnt=%0d want 10 cnt=0",
                     {busy, done}, match_count);
        end
        do_abort();
    endtask

    task automatic test_window();
        logic [4:0] seen_done;
        logic [3:0] bits = 4'b1011;
        apply_cfg(3'd4, 4'b1011, 1'b1, 8'd0, 16'd5);
        do_start();
        for (int i = 4; i >= 0; i--) begin send(1'b0); seen_done[i] = done; end
        n_checks++;
        if (seen_done !== 5'b00001) begin
            n_fail++;
            $display("FAIL window_done_seq: got %b want 00001", seen_done);
        end
        n_checks++;
        if ({timeout, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL window_timeout: got to/busy=%b want 10", {timeout, busy});
        end
        apply_cfg(3'd4, 4'b1011, 1'b1, 8'd1, 16'd4);
        n_checks++;
        if ({done, timeout} !== 2'b00) begin
            n_fail++;
            $display("FAIL cfg_clears_done: got done/to=%b want 00", {done, timeout});
        end
        do_start();
        for (int i = 3; i >= 0; i--) send(bits[i]);
        n_checks++;
        if ({done, timeout, match} !== 3'b101 || match_count !== 8'd1) begin
            n_fail++;
            $display("FAIL target_on_expiry: got done/to/match=%b cnt=%0d want 101 cnt=1",
                     {done, timeout, match}, match_count);
        end
    endtask

    task automatic test_bad_cfg();
        logic [2:0] bad [2] = '{3'd0, 3'd5};
        reset = 1'b1; tick(); reset = 1'b0; tick();
        foreach (bad[k]) begin
            apply_cfg(bad[k], 4'b1011, 1'b1, 8'd0, 16'd0);
            n_checks++;
            if (cfg_err !== 1'b1) begin
                n_fail++;
                $display("FAIL cfg_err_pulse len=%0d: got %b want 1", bad[k], cfg_err);
            end
            tick();
            n_checks++;
            if (cfg_err !== 1'b0) begin
                n_fail++;
                $display("FAIL cfg_err_one_cycle len=%0d: got %b want 0", bad[k], cfg_err);
            end
            do_start();
            n_checks++;
            if ({busy, cfg_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL idle_start_ignored len=%0d: got busy/rdy=%b want 01", bad[k], {busy, cfg_ready});
            end
        end
    endtask

    task automatic test_gaps_abort_reset();
        apply_cfg(3'd4, 4'b1011, 1'b1, 8'd0, 16'd0);
        do_start();
        send(1'b1); tick(); send(1'b0); tick(); tick(); send(1'b1); tick(); send(1'b1);
        n_checks++;
        if (match !== 1'b1 || match_count !== 8'd1) begin
            n_fail++;
            $display("FAIL gap_match: got match=%b cnt=%0d want 1 cnt=1", match, match_count);
        end
        send(1'b0);
        do_abort();
        n_checks++;
        if ({busy, done, timeout, cfg_ready} !== 4'b0001 || match_count !== 8'd1) begin
            n_fail++;
            $display("FAIL abort_armed: got busy/done/to/rdy=%b cnt=%0d want 0001 cnt=1",
                     {busy, done, timeout, cfg_ready}, match_count);
        end
        do_start();
        send(1'b1); send(1'b0); send(1'b1); send(1'b1);
        n_checks++;
        if (busy !== 1'b1 || match_count !== 8'd1) begin
            n_fail++;
            $display("FAIL rearm_run: got busy=%b cnt=%0d want 1 cnt=1", busy, match_count);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({cfg_ready, busy, done, timeout, match, cfg_err} !== 6'b100000 || match_count !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset: got rdy/busy/done/to/match/err=%b cnt=%0d want 100000 cnt=0",
                     {cfg_ready, busy, done, timeout, match, cfg_err}, match_count);
        end
        tick();
        reset = 1'b0;
        do_start();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_after_reset: got busy=%b want 0", busy);
        end
    endtask

    initial begin
        cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        cfg_target = '0; cfg_window = '0; start = 1'b0; abort = 1'b0;
        in_valid = 1'b0; in_bit = 1'b0;
        test_reset();
        test_overlap();
        test_no_overlap();
        test_target();
        test_window();
        test_bad_cfg();
        test_gaps_abort_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
